// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: drives PC/pipe-register enables and flushes.
// Latency: enables/flushes are combinational from state and inputs; FSM state and perf counters update on CLK.
// Backpressure: imem/dmem wait and load-use hold the upstream stages; halt drains the pipe and then freezes it.
module pipeline_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             branch_taken,
  input  logic             id_jump,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_halt,
  input  logic             memwb_halt,
  output logic             pc_WEN,
  output logic             ifid_WEN,
  output logic             idex_WEN,
  output logic             exmem_WEN,
  output logic             memwb_WEN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             flush_evt;
  logic             dmem_pending;
  logic             load_use;

  // A memory op sitting in EX/MEM that has not completed freezes everything up to MEM.
  assign dmem_pending = (exmem_MemRead | exmem_MemWrite) & ~dhit;

  // Register 0 is never a real dependency, so idex_rt==0 can never stall.
  assign load_use = idex_MemRead & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Next-state and enable/flush decode; rules are checked in priority order.
  always_comb begin
    state_d     = state_q;
    pc_WEN      = 1'b1;
    ifid_WEN    = 1'b1;
    idex_WEN    = 1'b1;
    exmem_WEN   = 1'b1;
    memwb_WEN   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    flush_evt   = 1'b0;

    if (RST) begin
      // Hold every register and load bubbles until reset releases.
      pc_WEN      = 1'b0;
      ifid_WEN    = 1'b0;
      idex_WEN    = 1'b0;
      exmem_WEN   = 1'b0;
      memwb_WEN   = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (dmem_pending) begin
            // Freeze up to MEM; WB receives a bubble so the stalled op is not retired twice.
            pc_WEN      = 1'b0;
            ifid_WEN    = 1'b0;
            idex_WEN    = 1'b0;
            exmem_WEN   = 1'b0;
            memwb_flush = 1'b1;
          end else if (branch_taken) begin
            // PC takes the target; the three younger wrong-path instructions are squashed.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_evt   = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID one cycle, insert a bubble into EX behind the load.
            pc_WEN      = 1'b0;
            ifid_WEN    = 1'b0;
            idex_flush  = 1'b1;
          end else if (id_jump) begin
            // Squash the delay-slot fetch; if the fetch has not returned, retry the jump next cycle.
            ifid_flush  = 1'b1;
            if (ihit) begin
              flush_evt = 1'b1;
            end else begin
              pc_WEN    = 1'b0;
            end
          end else if (!ihit) begin
            // Fetch still outstanding: hold PC and feed a NOP into ID.
            pc_WEN      = 1'b0;
            ifid_flush  = 1'b1;
          end

          if (idex_halt && !dmem_pending && !branch_taken) begin
            state_d = DRAIN;
          end
        end

        DRAIN: begin
          // No new instructions enter while the halt walks down to WB.
          pc_WEN     = 1'b0;
          ifid_flush = 1'b1;
          if (dmem_pending) begin
            ifid_WEN    = 1'b0;
            idex_WEN    = 1'b0;
            exmem_WEN   = 1'b0;
            memwb_flush = 1'b1;
          end else if (branch_taken) begin
            // The halt was on a wrong path: redirect and resume normal execution.
            pc_WEN      = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_evt   = 1'b1;
            state_d     = RUN;
          end else if (memwb_halt) begin
            state_d = HALTED;
          end
        end

        HALTED: begin
          pc_WEN    = 1'b0;
          ifid_WEN  = 1'b0;
          idex_WEN  = 1'b0;
          exmem_WEN = 1'b0;
          memwb_WEN = 1'b0;
          halted    = 1'b1;
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Saturating counters: stall cycles are any active cycle with the PC held, flushes are squash events.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((state_q == RUN || state_q == DRAIN) && !pc_WEN && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush_evt && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: two instances (32-bit and 4-bit counters) share all inputs.
// Outputs are checked #1 after inputs change and counters #1 after the rising edge.
// Expected values are hand-computed per vector.
module tb_pipeline_control;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, exmem_MemRead, exmem_MemWrite, branch_taken, id_jump;
  logic       idex_MemRead, idex_halt, memwb_halt;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic        pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [31:0] stall_count, flush_count;

  logic        s_pc_WEN, s_ifid_WEN, s_idex_WEN, s_exmem_WEN, s_memwb_WEN;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halted;
  logic [3:0]  s_stall_count, s_flush_count;

  int errs   = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pipeline_control #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .branch_taken(branch_taken), .id_jump(id_jump),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_halt(idex_halt), .memwb_halt(memwb_halt),
    .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .idex_WEN(idex_WEN),
    .exmem_WEN(exmem_WEN), .memwb_WEN(memwb_WEN),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_control #(.CNT_W(4)) dut_s (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .branch_taken(branch_taken), .id_jump(id_jump),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_halt(idex_halt), .memwb_halt(memwb_halt),
    .pc_WEN(s_pc_WEN), .ifid_WEN(s_ifid_WEN), .idex_WEN(s_idex_WEN),
    .exmem_WEN(s_exmem_WEN), .memwb_WEN(s_memwb_WEN),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush),
    .halted(s_halted), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {pc, ifid, idex, exmem, memwb} enables and {ifid, idex, exmem, memwb} flushes.
  function automatic logic [4:0] wen_vec();
    return {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN};
  endfunction

  function automatic logic [3:0] fl_vec();
    return {ifid_flush, idex_flush, exmem_flush, memwb_flush};
  endfunction

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0;
    branch_taken = 1'b0; id_jump = 1'b0; idex_MemRead = 1'b0;
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    idex_halt = 1'b0; memwb_halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic [4:0] wen, input logic [3:0] fl, input logic h);
    #1;
    check_eq({tag, ".wen"}, 64'(wen_vec()), 64'(wen));
    check_eq({tag, ".flush"}, 64'(fl_vec()), 64'(fl));
    check_eq({tag, ".halted"}, 64'(halted), 64'(h));
  endtask

  task automatic check_cnt(input string tag, input int st, input int fc);
    check_eq({tag, ".stall"}, 64'(stall_count), 64'(st));
    check_eq({tag, ".flushcnt"}, 64'(flush_count), 64'(fc));
  endtask

  initial begin
    // Reset state: everything held, bubbles everywhere.
    RST = 1'b1;
    idle();
    check_ctl("reset", 5'b00000, 4'b1111, 1'b0);
    tick();
    check_cnt("reset", 0, 0);
    RST = 1'b0;

    // Idle RUN.
    check_ctl("run_idle", 5'b11111, 4'b0000, 1'b0);
    tick();
    check_cnt("run_idle", 0, 0);

    // lw $2 ; add $3,$2,$1 -> one load-use bubble.
    idex_MemRead = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2; ifid_rt = 5'd1;
    check_ctl("load_use", 5'b00111, 4'b0100, 1'b0);
    tick();
    idle();
    check_ctl("load_use_after", 5'b11111, 4'b0000, 1'b0);
    check_cnt("load_use", 1, 0);
    tick();

    // Load targeting $0 against rs/rt=0 never stalls.
    idex_MemRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    check_ctl("load_r0", 5'b11111, 4'b0000, 1'b0);
    tick();
    check_cnt("load_r0", 1, 0);
    idle();

    // dmem miss for 3 cycles, then hit.
    exmem_MemRead = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_ctl($sformatf("dmem_wait%0d", i), 5'b00001, 4'b0001, 1'b0);
      tick();
    end
    dhit = 1'b1;
    check_ctl("dmem_hit", 5'b11111, 4'b0000, 1'b0);
    tick();
    check_cnt("dmem", 4, 0);
    idle();

    // Branch overrides load-use and fetch miss.
    branch_taken = 1'b1; ihit = 1'b0;
    idex_MemRead = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2;
    check_ctl("branch", 5'b11111, 4'b1110, 1'b0);
    tick();
    check_cnt("branch", 4, 1);
    idle();

    // Jump while fetch outstanding: retried, not counted until ihit.
    id_jump = 1'b1; ihit = 1'b0;
    check_ctl("jump_miss", 5'b01111, 4'b1000, 1'b0);
    tick();
    check_cnt("jump_miss", 5, 1);
    ihit = 1'b1;
    check_ctl("jump_hit", 5'b11111, 4'b1000, 1'b0);
    tick();
    check_cnt("jump_hit", 5, 2);
    idle();

    // Plain fetch miss.
    ihit = 1'b0;
    check_ctl("imiss", 5'b01111, 4'b1000, 1'b0);
    tick();
    check_cnt("imiss", 6, 2);
    idle();

    // Halt in ID/EX, reaches MEM/WB two cycles later.
    idex_halt = 1'b1;
    check_ctl("halt_run", 5'b11111, 4'b0000, 1'b0);
    tick();
    idex_halt = 1'b0;
    check_ctl("drain1", 5'b01111, 4'b1000, 1'b0);
    tick();
    memwb_halt = 1'b1;
    check_ctl("drain2", 5'b01111, 4'b1000, 1'b0);
    tick();
    check_cnt("drain", 8, 2);
    memwb_halt = 1'b0; ihit = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_ctl($sformatf("halted%0d", i), 5'b00000, 4'b0000, 1'b1);
      tick();
    end
    check_cnt("halted_frozen", 8, 2);
    idle();

    // Reset out of HALTED.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_cnt("rst_halted", 0, 0);

    // Branch taken during DRAIN returns to RUN.
    idex_halt = 1'b1;
    tick();
    idex_halt = 1'b0; branch_taken = 1'b1;
    check_ctl("drain_branch", 5'b11111, 4'b1110, 1'b0);
    tick();
    idle();
    check_ctl("drain_branch_run", 5'b11111, 4'b0000, 1'b0);
    check_cnt("drain_branch", 0, 1);
    tick();

    // Reset mid-DRAIN.
    idex_halt = 1'b1;
    tick();
    idex_halt = 1'b0;
    check_ctl("drain_pre_rst", 5'b01111, 4'b1000, 1'b0);
    RST = 1'b1;
    check_ctl("rst_in_drain", 5'b00000, 4'b1111, 1'b0);
    tick();
    RST = 1'b0;
    check_ctl("rst_drain_run", 5'b11111, 4'b0000, 1'b0);
    check_cnt("rst_drain", 0, 0);

    // Saturation: 15 stalls fill the 4-bit counter, 2 more must not wrap.
    ihit = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_eq("sat15.small", 64'(s_stall_count), 64'hF);
    check_eq("sat15.wide", 64'(stall_count), 64'd15);
    for (int i = 0; i < 2; i++) tick();
    check_eq("sat17.small", 64'(s_stall_count), 64'hF);
    check_eq("sat17.wide", 64'(stall_count), 64'd17);
    check_eq("sat17.small_pc", 64'(s_pc_WEN), 64'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives WEN/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable.
- Handles imem/dmem wait, load-use stall, jump/branch squash and halt drain.
- Keeps saturating stall/flush performance counters for the datapath top.

Parameters:
- CNT_W, 32, width of stall_count and flush_count.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous active-high reset
- ihit  input  1  instruction fetch completed this cycle
- dhit  input  1  data access completed this cycle
- exmem_MemRead  input  1  M_MemRead_out of EX/MEM
- exmem_MemWrite  input  1  M_MemWrite_out of EX/MEM
- branch_taken  input  1  branch resolved taken in MEM stage
- id_jump  input  1  J/JAL/JR decoded in ID
- idex_MemRead  input  1  M_MemRead_out of ID/EX
- idex_rt  input  5  rt_out of ID/EX
- ifid_rs  input  5  rs field of IF/ID instruction_out
- ifid_rt  input  5  rt field of IF/ID instruction_out
- idex_halt  input  1  halt_out of ID/EX
- memwb_halt  input  1  halt_out of MEM/WB
- pc_WEN  output  1  PC register load enable
- ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN  output  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load NOP/bubble
- halted  output  1  pipeline drained and stopped
- stall_count  output  CNT_W  cycles with pc_WEN=0 in RUN/DRAIN
- flush_count  output  CNT_W  branch/jump squash events

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset (sync, RST=1 at posedge) -> RUN; counters cleared to 0.
- While RST=1: all WEN=0, all flush=1, halted=0.
- Enable/flush outputs are combinational from state and inputs; state and counters are registered.
- Default in RUN: all WEN=1, all flush=0.
- dmem_pending = (exmem_MemRead|exmem_MemWrite) & ~dhit.
- load_use = idex_MemRead & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- Priority in RUN, highest first:
  1. dmem_pending: pc/ifid/idex/exmem WEN=0; memwb_WEN=1, memwb_flush=1 (bubble into WB). All lower rules suppressed.
  2. branch_taken: pc_WEN=1 (target); ifid_flush=idex_flush=exmem_flush=1; flush_count+1. Overrides load_use, id_jump, ~ihit.
  3. load_use: pc_WEN=0, ifid_WEN=0, idex_flush=1; EX/MEM and MEM/WB advance.
  4. id_jump: ifid_flush=1, pc_WEN=1; flush_count+1. If also ~ihit: pc_WEN=0, ifid_flush=1; jump retried, counted only on the cycle ihit=1.
  5. ~ihit: pc_WEN=0, ifid_flush=1; rest advance.
- RUN -> DRAIN when idex_halt=1 and neither dmem_pending nor branch_taken is active.
- DRAIN:
  - pc_WEN=0, ifid_flush=1 every cycle; idex/exmem/memwb follow rules 1-2.
  - branch_taken in DRAIN (halt on wrong path): apply rule 2, return to RUN.
  - memwb_halt=1 (and no dmem_pending) -> HALTED.
- HALTED: all WEN=0, flush=0, halted=1; counters frozen; exit only via RST.
- stall_count +1 each cycle in RUN/DRAIN with pc_WEN=0; excludes the reset cycle and HALTED.
- Both counters saturate at all-ones; no wrap.
- A load_use with ifid_rs/rt=0 against idex_rt=0 never stalls.

Test Plan:
- lw $2 followed by add $3,$2,$1 (idex_MemRead=1, idex_rt=2, ifid_rs=2) -> exactly one cycle with pc_WEN=0, ifid_WEN=0, idex_flush=1; stall_count=1.
- Same pair with idex_rt=0 -> no stall, all WEN=1.
- exmem_MemRead=1, dhit=0 for 3 cycles then 1 -> 3 cycles with pc/ifid/idex/exmem WEN=0 and memwb_flush=1; 4th cycle all WEN=1; stall_count=3.
- branch_taken=1 with load_use=1 and ihit=0 simultaneously -> pc_WEN=1, ifid/idex/exmem_flush=1, idex_WEN not gated; flush_count=1.
- idex_halt=1, memwb_halt asserted 2 cycles later -> DRAIN for 2 cycles (pc_WEN=0, ifid_flush=1), then halted=1 and all WEN=0 held for 10 cycles.
- DRAIN with branch_taken=1 -> back in RUN, flushes asserted, halted stays 0.
- RST=1 mid-DRAIN -> next cycle RUN, counters 0.
- stall_count preloaded near max with CNT_W=4 (15 stalls, then 2 more) -> stays 4'hF.
